// File: rtl/sp_ram_word_bridge_if.sv
// Bus bundle between a picorv32 native memory port, the word-to-byte bridge
// and one byte-wide single-port block RAM.
interface sp_ram_word_bridge_if #(
    parameter int unsigned ADDR_BITS = 11
);
    // CPU side
    logic                 mem_valid;
    logic                 mem_sel;
    logic [31:0]          mem_addr;
    logic [3:0]           mem_wstrb;
    logic [31:0]          mem_wdata;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;

    // RAM side
    logic                 ram_ce;
    logic                 ram_oce;
    logic                 ram_wre;
    logic [ADDR_BITS-1:0] ram_ad;
    logic [7:0]           ram_din;
    logic [7:0]           ram_dout;

    // Environment view: CPU issuing requests plus the RAM answering reads
    modport master (
        output mem_valid, mem_sel, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata,
        input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
        output ram_dout
    );

    // Bridge view
    modport slave (
        input  mem_valid, mem_sel, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata,
        output ram_ce, ram_oce, ram_wre, ram_ad, ram_din,
        input  ram_dout
    );
endinterface

// File: rtl/sp_ram_word_bridge.sv
// Splits each 32-bit picorv32 transaction into four sequential byte accesses
// on a 2048x8 single-port block RAM with one-cycle read latency.
module sp_ram_word_bridge #(
    parameter int unsigned ADDR_BITS = 11
) (
    input  logic                clk,
    input  logic                reset,
    sp_ram_word_bridge_if.slave bus
);

    localparam int unsigned IDX_W = ADDR_BITS - 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_TAIL = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic [31:0]       rdata_q;

    logic              ram_ce_c;
    logic              ram_wre_c;
    logic [ADDR_BITS-1:0] ram_ad_c;
    logic [7:0]        ram_din_c;
    logic [1:0]        prev_byte_c;

    // Word offset bits and the region above the RAM are decoded elsewhere
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_BITS], bus.mem_addr[1:0]};

    // Byte whose read data arrives on ram_dout during an RD cycle
    assign prev_byte_c = cnt_q - 2'd1;

    // Sequencer: latches the request, steps the byte counter, assembles read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_valid && bus.mem_sel) begin
                        idx_q   <= bus.mem_addr[ADDR_BITS-1:2];
                        wstrb_q <= bus.mem_wstrb;
                        wdata_q <= bus.mem_wdata;
                        cnt_q   <= 2'd0;
                        state_q <= (bus.mem_wstrb == 4'd0) ? S_RD : S_WR;
                    end
                end
                S_RD: begin
                    if (cnt_q != 2'd0) begin
                        rdata_q[{prev_byte_c, 3'b000} +: 8] <= bus.ram_dout;
                    end
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= S_RD_TAIL;
                    end
                end
                S_RD_TAIL: begin
                    rdata_q[31:24] <= bus.ram_dout;
                    ready_q        <= 1'b1;
                    state_q        <= S_DONE;
                end
                S_WR: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // RAM strobes decoded from state so that reset drops them immediately
    always_comb begin
        ram_ce_c  = 1'b0;
        ram_wre_c = 1'b0;
        ram_ad_c  = '0;
        ram_din_c = 8'd0;
        case (state_q)
            S_RD: begin
                ram_ce_c = 1'b1;
                ram_ad_c = {idx_q, cnt_q};
            end
            S_WR: begin
                ram_ce_c  = wstrb_q[cnt_q];
                ram_wre_c = wstrb_q[cnt_q];
                ram_ad_c  = {idx_q, cnt_q};
                ram_din_c = wdata_q[{cnt_q, 3'b000} +: 8];
            end
            default: begin
            end
        endcase
    end

    assign bus.ram_ce    = ram_ce_c;
    assign bus.ram_oce   = ram_ce_c;
    assign bus.ram_wre   = ram_wre_c;
    assign bus.ram_ad    = ram_ad_c;
    assign bus.ram_din   = ram_din_c;
    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_sp_ram_word_bridge.sv
// Bench for sp_ram_word_bridge: behavioural byte RAM, reference memory and a
// scoreboard queue of expected mem_rdata values, one entry per completion.
module tb_sp_ram_word_bridge;

    localparam int unsigned AB = 11;

    logic clk;
    logic reset;
    logic ram_clear;
    logic pl_en;
    logic [AB-1:0] pl_addr;
    logic [7:0] pl_data;

    int tests_run;
    int tests_failed;
    int ready_pulses;

    logic [7:0]  ram_mem [0:2047];
    logic [7:0]  ref_mem [0:2047];
    logic [31:0] sb_q [$];
    logic [31:0] exp_rdata;

    sp_ram_word_bridge_if #(.ADDR_BITS(AB)) bus ();

    sp_ram_word_bridge #(.ADDR_BITS(AB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte RAM: one-cycle read latency, bypass (write data appears on dout)
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 2048; i++) ram_mem[i] <= 8'd0;
        end else if (pl_en) begin
            ram_mem[pl_addr] <= pl_data;
        end else if (bus.ram_ce === 1'b1) begin
            if (bus.ram_wre === 1'b1) begin
                ram_mem[bus.ram_ad] <= bus.ram_din;
                bus.ram_dout        <= bus.ram_din;
            end else begin
                bus.ram_dout <= ram_mem[bus.ram_ad];
            end
        end
    end

    // Completion pulse counter
    always @(posedge clk) begin
        if (reset) ready_pulses <= ready_pulses;
        else if (bus.mem_ready === 1'b1) ready_pulses <= ready_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int a;
        a = int'({addr[AB-1:2], 2'b00});
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic preload(input int a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = AB'(a);
        pl_data = d;
        ref_mem[a] = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        bus.mem_valid = 1'b1;
        bus.mem_sel   = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wstrb = wstrb;
        bus.mem_wdata = wdata;
    endtask

    // Record the expected outcome of a transaction in the reference model
    task automatic sb_push(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        int a;
        a = int'({addr[AB-1:2], 2'b00});
        if (wstrb == 4'd0) begin
            exp_rdata = ref_word(addr);
        end else begin
            for (int k = 0; k < 4; k++)
                if (wstrb[k]) ref_mem[a+k] = wdata[8*k +: 8];
        end
        sb_q.push_back(exp_rdata);
    endtask

    task automatic issue(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
        drive(addr, wstrb, wdata);
        sb_push(addr, wstrb, wdata);
    endtask

    function automatic logic [31:0] sb_pop();
        if (sb_q.size() == 0) return 32'hxxxx_xxxx;
        return sb_q.pop_front();
    endfunction

    // Step cycles until mem_ready; lat = cycles elapsed, -1 on timeout
    task automatic wait_ready(input int budget, input bit hold, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = 32'hxxxx_xxxx;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (!hold && c == 1) bus.mem_valid = 1'b0;
            if (bus.mem_ready === 1'b1) begin
                lat = c;
                rd  = bus.mem_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.mem_ready, bus.ram_ce, bus.ram_oce, bus.ram_wre} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_strobes: got ready/ce/oce/wre=%b, expected 0000",
                     {bus.mem_ready, bus.ram_ce, bus.ram_oce, bus.ram_wre});
        end
        tests_run++;
        if ({bus.mem_rdata, bus.ram_ad, bus.ram_din} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got rdata=%h ad=%h din=%h, expected all 0",
                     bus.mem_rdata, bus.ram_ad, bus.ram_din);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        logic [31:0] exp;
        preload(4, 8'h11);
        preload(5, 8'h22);
        preload(6, 8'h33);
        preload(7, 8'h44);
        tick();
        issue(32'h0000_0004, 4'b0000, 32'h0);
        tests_run++;
        if (bus.ram_ce !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_c0_ce: got %b, expected 0", bus.ram_ce);
        end
        tick();
        bus.mem_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({bus.ram_ce, bus.ram_oce, bus.ram_wre, bus.ram_ad, bus.mem_ready} !==
                {1'b1, 1'b1, 1'b0, AB'(4 + k), 1'b0}) begin
                tests_failed++;
                $display("FAIL read_c%0d: got ce=%b oce=%b wre=%b ad=%0d ready=%b, expected ce=1 oce=1 wre=0 ad=%0d ready=0",
                         k + 1, bus.ram_ce, bus.ram_oce, bus.ram_wre, bus.ram_ad, bus.mem_ready, 4 + k);
            end
            tick();
        end
        tests_run++;
        if ({bus.ram_ce, bus.mem_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_c5: got ce=%b ready=%b, expected 0 0", bus.ram_ce, bus.mem_ready);
        end
        tick();
        exp = sb_pop();
        tests_run++;
        if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== exp) begin
            tests_failed++;
            $display("FAIL read_c6: got ready=%b rdata=%h, expected ready=1 rdata=%h",
                     bus.mem_ready, bus.mem_rdata, exp);
        end
        tick();
        tests_run++;
        if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== exp) begin
            tests_failed++;
            $display("FAIL read_c7: got ready=%b rdata=%h, expected ready=0 rdata=%h held",
                     bus.mem_ready, bus.mem_rdata, exp);
        end
    endtask

    task automatic test_partial_write();
        logic [3:0]  ws;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [31:0] rd;
        int          lat;
        ws = 4'b0101;
        wd = 32'hAABB_CCDD;
        tick();
        issue(32'h0000_0008, ws, wd);
        tick();
        bus.mem_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if ({bus.ram_ce, bus.ram_wre, bus.ram_ad, bus.mem_ready} !== {ws[k], ws[k], AB'(8 + k), 1'b0} ||
                (ws[k] && bus.ram_din !== wd[8*k +: 8])) begin
                tests_failed++;
                $display("FAIL pwrite_c%0d: got ce=%b wre=%b ad=%0d din=%h ready=%b, expected ce=%b wre=%b ad=%0d din=%h ready=0",
                         k + 1, bus.ram_ce, bus.ram_wre, bus.ram_ad, bus.ram_din, bus.mem_ready,
                         ws[k], ws[k], 8 + k, wd[8*k +: 8]);
            end
            tick();
        end
        exp = sb_pop();
        tests_run++;
        if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== exp) begin
            tests_failed++;
            $display("FAIL pwrite_c5: got ready=%b rdata=%h, expected ready=1 rdata=%h unchanged",
                     bus.mem_ready, bus.mem_rdata, exp);
        end
        tick();
        issue(32'h0000_0008, 4'b0000, 32'h0);
        wait_ready(20, 1'b0, lat, rd);
        exp = sb_pop();
        tests_run++;
        if (lat !== 6 || rd !== exp) begin
            tests_failed++;
            $display("FAIL pwrite_readback: got lat=%0d rdata=%h, expected lat=6 rdata=%h", lat, rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        int          p0;
        int          lat;
        logic [31:0] rd;
        logic [31:0] exp;
        tick();
        p0 = ready_pulses;
        issue(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
        tick();
        bus.mem_wstrb = 4'b0000;
        bus.mem_wdata = 32'h0;
        sb_push(32'h0000_0010, 4'b0000, 32'h0);
        wait_ready(20, 1'b1, lat, rd);
        exp = sb_pop();
        tests_run++;
        if (lat !== 4 || rd !== exp) begin
            tests_failed++;
            $display("FAIL b2b_write: got lat=%0d rdata=%h, expected lat=4 rdata=%h", lat, rd, exp);
        end
        wait_ready(20, 1'b1, lat, rd);
        exp = sb_pop();
        tests_run++;
        if (lat !== 7 || rd !== exp) begin
            tests_failed++;
            $display("FAIL b2b_read: got lat=%0d rdata=%h, expected lat=7 rdata=%h", lat, rd, exp);
        end
        bus.mem_valid = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (ready_pulses - p0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_pulses: got %0d, expected 2", ready_pulses - p0);
        end
    endtask

    task automatic test_reset_mid_write();
        int          p0;
        int          lat;
        logic [31:0] rd;
        logic [31:0] exp;
        tick();
        p0 = ready_pulses;
        drive(32'h0000_0020, 4'b1111, 32'hCAFE_F00D);
        tick();
        bus.mem_valid = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.ram_ce, bus.ram_wre, bus.mem_ready} !== 3'b000 || bus.mem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got ce=%b wre=%b ready=%b rdata=%h, expected 0 0 0 00000000",
                     bus.ram_ce, bus.ram_wre, bus.mem_ready, bus.mem_rdata);
        end
        // Only bytes 0 and 1 reached the RAM before the abort
        ref_mem[32] = 8'h0D;
        ref_mem[33] = 8'hF0;
        exp_rdata   = 32'h0;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        tests_run++;
        if (ready_pulses !== p0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_ready: got %0d pulses, expected 0", ready_pulses - p0);
        end
        issue(32'h0000_0020, 4'b0000, 32'h0);
        wait_ready(20, 1'b0, lat, rd);
        exp = sb_pop();
        tests_run++;
        if (lat !== 6 || rd !== exp) begin
            tests_failed++;
            $display("FAIL rst_mid_readback: got lat=%0d rdata=%h, expected lat=6 rdata=%h", lat, rd, exp);
        end
    endtask

    task automatic test_unselected();
        int p0;
        tick();
        p0 = ready_pulses;
        drive(32'h0000_0004, 4'b0000, 32'h0);
        bus.mem_sel = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if ({bus.ram_ce, bus.mem_ready} !== 2'b00) begin
                tests_failed++;
                $display("FAIL unsel_c%0d: got ce=%b ready=%b, expected 0 0", c, bus.ram_ce, bus.mem_ready);
            end
        end
        bus.mem_valid = 1'b0;
        tick();
        tests_run++;
        if (ready_pulses !== p0) begin
            tests_failed++;
            $display("FAIL unsel_pulses: got %0d, expected 0", ready_pulses - p0);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        ready_pulses  = 0;
        exp_rdata     = 32'h0;
        reset         = 1'b1;
        ram_clear     = 1'b1;
        pl_en         = 1'b0;
        pl_addr       = '0;
        pl_data       = 8'h0;
        bus.mem_valid = 1'b0;
        bus.mem_sel   = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = 32'h0;
        bus.ram_dout  = 8'h0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h0;
        tick();
        ram_clear = 1'b0;
        reset     = 1'b0;
        tick();

        test_reset();
        test_read();
        test_partial_write();
        test_back_to_back();
        test_reset_mid_write();
        test_unselected();

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
